// File: rtl/cam_threshold_writer.sv
// cam_threshold_writer
//   Camera-side front end for the 1-bit SPRAM frame buffer. Takes the parallel
//   camera byte stream (vsync/href/data, YUV422), picks out the luma byte of
//   every pixel, binarizes it against a per-frame threshold and emits
//   sequential single-bit pixel writes plus a per-frame done/error pulse.
//
//   Ports
//     w_clk        camera pixel clock, rising edge
//     w_rst_n      asynchronous active-low reset
//     cam_vsync    frame sync (high in vertical blank)
//     cam_href     line valid
//     cam_data     camera byte
//     threshold    binarization level, latched at frame start
//     enable       capture enable, sampled at frame start
//     wr_en        one-cycle pixel write strobe
//     wr_addr      pixel address, row-major
//     wr_data      binarized pixel
//     frame_done   pulse: complete well-formed frame written
//     frame_error  pulse: malformed frame discarded
//     busy         high while capturing a frame
//
//   state  | meaning
//   SYNC   | after reset; wait for vsync high so a partial frame is never taken
//   VBLANK | vertical blank; start a frame on vsync fall if enabled
//   ACTIVE | capturing lines; vsync rise closes and judges the frame
module cam_threshold_writer #(
    parameter int H_PIXELS        = 320,
    parameter int V_LINES         = 240,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int Y_BYTE_IDX      = 1,
    parameter bit INVERT          = 1'b0
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic [7:0]  threshold,
    input  logic        enable,
    output logic        wr_en,
    output logic [16:0] wr_addr,
    output logic        wr_data,
    output logic        frame_done,
    output logic        frame_error,
    output logic        busy
);

    localparam int COL_W = $clog2(H_PIXELS + 2);
    localparam int ROW_W = $clog2(V_LINES + 2);
    localparam int PH_W  = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;

    localparam logic [COL_W-1:0] COL_H    = COL_W'(H_PIXELS);
    localparam logic [COL_W-1:0] COL_SAT  = COL_W'(H_PIXELS + 1);
    localparam logic [ROW_W-1:0] ROW_V    = ROW_W'(V_LINES);
    localparam logic [PH_W-1:0]  PH_Y     = PH_W'(Y_BYTE_IDX);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BYTES_PER_PIXEL - 1);
    localparam logic [16:0]      ADDR_H   = 17'(H_PIXELS);
    localparam logic [16:0]      PIX_ALL  = 17'(H_PIXELS * V_LINES);

    typedef enum logic [1:0] {ST_SYNC, ST_VBLANK, ST_ACTIVE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_vs1, r_vs2, r_hs1, r_hs2;
    logic [7:0]       r_d1;
    logic [7:0]       r_thr;
    logic [COL_W-1:0] r_col;
    logic [PH_W-1:0]  r_phase;
    logic [ROW_W-1:0] r_row;
    logic [16:0]      r_base;
    logic [16:0]      r_pix;
    logic             r_err;

    logic             w_vs_rise, w_vs_fall, w_hs_rise, w_hs_fall;
    logic             w_start, w_eval, w_capture;
    logic [COL_W-1:0] w_col_eff;
    logic [PH_W-1:0]  w_ph_eff;
    logic             w_ph_last, w_write, w_line_end, w_line_bad, w_frame_ok;

    assign w_vs_rise = r_vs1 & ~r_vs2;
    assign w_vs_fall = ~r_vs1 & r_vs2;
    assign w_hs_rise = r_hs1 & ~r_hs2;
    assign w_hs_fall = ~r_hs1 & r_hs2;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= ST_SYNC;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC:   if (r_vs1)                w_state_nxt = ST_VBLANK;
            ST_VBLANK: if (w_vs_fall && enable)  w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_vs_rise)            w_state_nxt = ST_VBLANK;
            default:                             w_state_nxt = ST_SYNC;
        endcase
    end

    // The vsync-rise cycle only judges the frame; bytes seen then are dropped
    // so the last write always leads frame_done by at least one cycle.
    always_comb begin
        w_start   = (r_state == ST_VBLANK) && w_vs_fall && enable;
        w_eval    = (r_state == ST_ACTIVE) && w_vs_rise;
        w_capture = (r_state == ST_ACTIVE) && !w_vs_rise;
        busy      = (r_state == ST_ACTIVE);
    end

    // On the href rising cycle the counters are treated as already cleared.
    assign w_col_eff  = w_hs_rise ? '0 : r_col;
    assign w_ph_eff   = w_hs_rise ? '0 : r_phase;
    assign w_ph_last  = (w_ph_eff == PH_LAST);
    assign w_write    = w_capture && r_hs1 && (w_ph_eff == PH_Y) &&
                        (w_col_eff < COL_H) && (r_row < ROW_V);
    // A nonzero phase at line end means href dropped mid-pixel.
    assign w_line_end = (r_state == ST_ACTIVE) && w_hs_fall;
    assign w_line_bad = w_line_end &&
                        ((r_col != COL_H) || (r_phase != '0) || (r_row >= ROW_V));
    assign w_frame_ok = (r_pix == PIX_ALL) && !r_err && !w_line_bad;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_vs1       <= 1'b0;
            r_vs2       <= 1'b0;
            r_hs1       <= 1'b0;
            r_hs2       <= 1'b0;
            r_d1        <= '0;
            r_thr       <= '0;
            r_col       <= '0;
            r_phase     <= '0;
            r_row       <= '0;
            r_base      <= '0;
            r_pix       <= '0;
            r_err       <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            r_vs1 <= cam_vsync;
            r_vs2 <= r_vs1;
            r_hs1 <= cam_href;
            r_hs2 <= r_hs1;
            r_d1  <= cam_data;

            if (w_start) begin
                r_thr   <= threshold;
                r_col   <= '0;
                r_phase <= '0;
                r_row   <= '0;
                r_base  <= '0;
                r_pix   <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_capture && r_hs1) begin
                    r_phase <= w_ph_last ? '0 : w_ph_eff + 1'b1;
                    // Column saturates one past the line width: enough to
                    // flag long lines without wrapping.
                    if (w_ph_last && (w_col_eff != COL_SAT)) r_col <= w_col_eff + 1'b1;
                    else                                     r_col <= w_col_eff;
                end
                if (w_write) r_pix <= r_pix + 1'b1;
                if (w_line_end) begin
                    if (r_row < ROW_V) begin
                        r_row  <= r_row + 1'b1;
                        r_base <= r_base + ADDR_H;
                    end
                    if (w_line_bad) r_err <= 1'b1;
                end
            end

            wr_en <= w_write;
            if (w_write) begin
                wr_addr <= r_base + 17'(w_col_eff);
                wr_data <= (r_d1 >= r_thr) ^ INVERT;
            end
            frame_done  <= w_eval && w_frame_ok;
            frame_error <= w_eval && !w_frame_ok;
        end
    end

endmodule

// File: tb/tb_cam_threshold_writer.sv
module tb_cam_threshold_writer;

    localparam int H      = 16;
    localparam int V      = 8;
    localparam int BPP    = 2;
    localparam int YI     = 1;
    localparam int LINE_B = H * BPP;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = '0;
    logic [7:0]  threshold = 8'h80;
    logic        enable = 1'b1;

    logic        wr_en, wr_data, frame_done, frame_error, busy;
    logic [16:0] wr_addr;
    logic        wr_en_i, wr_data_i, frame_done_i, frame_error_i, busy_i;
    logic [16:0] wr_addr_i;

    cam_threshold_writer #(.H_PIXELS(H), .V_LINES(V), .BYTES_PER_PIXEL(BPP),
                           .Y_BYTE_IDX(YI), .INVERT(1'b0)) dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .threshold(threshold), .enable(enable),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .frame_error(frame_error), .busy(busy));

    cam_threshold_writer #(.H_PIXELS(H), .V_LINES(V), .BYTES_PER_PIXEL(BPP),
                           .Y_BYTE_IDX(YI), .INVERT(1'b1)) dut_inv (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .threshold(threshold), .enable(enable),
        .wr_en(wr_en_i), .wr_addr(wr_addr_i), .wr_data(wr_data_i),
        .frame_done(frame_done_i), .frame_error(frame_error_i), .busy(busy_i));

    always #5 w_clk = ~w_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each expected write is {address, pixel bit} for the
    // non-inverted instance; the inverted one must write the complement.
    logic [17:0] exp_q[$];
    bit          model_active = 1'b0;
    logic [7:0]  frame_thr = '0;
    int n_done = 0, n_err = 0, n_done_i = 0, n_err_i = 0;

    always @(negedge w_clk) begin
        logic [17:0] e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check_val("wr_unexpected", wr_en, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("wr_addr", wr_addr, e[17:1]);
                check_val("wr_data", wr_data, e[0]);
                check_val("inv_wr_en", wr_en_i, 1);
                check_val("inv_wr_addr", wr_addr_i, e[17:1]);
                check_val("inv_wr_data", wr_data_i, !e[0]);
            end
        end else begin
            check_val("inv_wr_idle", wr_en_i, 0);
        end
        if (frame_done) begin
            n_done++;
            check_val("done_with_wr", wr_en, 0);
        end
        if (frame_error)   n_err++;
        if (frame_done_i)  n_done_i++;
        if (frame_error_i) n_err_i++;
    end

    task automatic drive(input logic v, input logic h, input logic [7:0] d);
        cam_vsync = v;
        cam_href  = h;
        cam_data  = d;
        @(negedge w_clk);
    endtask

    function automatic logic [7:0] pick(input logic [7:0] thr);
        case ($urandom_range(0, 3))
            0:       return 8'(thr - 8'd1);
            1:       return thr;
            2:       return 8'(thr + 8'd1);
            default: return 8'($urandom);
        endcase
    endfunction

    // Reset pulse placed off the clock edges, after the monitor has sampled.
    task automatic reset_pulse();
        #2 w_rst_n = 1'b0;
        #1;
        check_val("rst_wr_en", wr_en, 0);
        check_val("rst_wr_addr", wr_addr, 0);
        check_val("rst_wr_data", wr_data, 0);
        check_val("rst_done", frame_done, 0);
        check_val("rst_error", frame_error, 0);
        check_val("rst_busy", busy, 0);
        exp_q.delete();
        model_active = 1'b0;
        @(negedge w_clk);
        @(negedge w_clk);
        #2 w_rst_n = 1'b1;
        @(negedge w_clk);
    endtask

    task automatic run_frame(input int nlines, input int bad_row, input int bad_len,
                             input bit en, input logic [7:0] thr, input logic [7:0] thr_mid,
                             input int rst_row, input int const_luma);
        int len, nd, ne, ndi, nei;
        bit ok;
        logic [7:0] d;
        threshold = thr;
        enable    = en;
        repeat (4) drive(1'b1, 1'b0, 8'h00);
        model_active = en;
        frame_thr    = thr;
        ok           = (nlines == V);
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        for (int r = 0; r < nlines; r++) begin
            check_val("busy", busy, model_active);
            len = (r == bad_row) ? bad_len : LINE_B;
            if (r < V && len != LINE_B) ok = 1'b0;
            for (int b = 0; b < len; b++) begin
                d = (const_luma >= 0) ? const_luma[7:0] : pick(frame_thr);
                if (model_active && r < V && (b % BPP) == YI && (b / BPP) < H)
                    exp_q.push_back({17'(r * H + b / BPP), d >= frame_thr});
                drive(1'b0, 1'b1, d);
                if (r == rst_row && b == LINE_B / 2) reset_pulse();
            end
            repeat (3) drive(1'b0, 1'b0, 8'h00);
            if (r == 1) threshold = thr_mid;
        end
        nd = n_done; ne = n_err; ndi = n_done_i; nei = n_err_i;
        repeat (6) drive(1'b1, 1'b0, 8'h00);
        check_val("frame_done", n_done - nd, model_active && ok);
        check_val("frame_error", n_err - ne, model_active && !ok);
        check_val("inv_frame_done", n_done_i - ndi, model_active && ok);
        check_val("inv_frame_error", n_err_i - nei, model_active && !ok);
        check_val("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Held in reset with vsync low and href toggling; release mid-line.
        repeat (3) drive(1'b0, 1'b0, 8'h00);
        check_val("init_wr_en", wr_en, 0);
        check_val("init_wr_addr", wr_addr, 0);
        check_val("init_done", frame_done, 0);
        check_val("init_error", frame_error, 0);
        check_val("init_busy", busy, 0);
        for (int r = 0; r < 3; r++) begin
            for (int b = 0; b < LINE_B; b++) begin
                drive(1'b0, 1'b1, 8'($urandom));
                if (r == 0 && b == 10) #2 w_rst_n = 1'b1;
            end
            repeat (3) drive(1'b0, 1'b0, 8'h00);
        end
        check_val("startup_busy", busy, 0);

        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h80, -1, -1);          // nominal
        run_frame(V, 3, LINE_B - 2, 1'b1, 8'h80, 8'h80, -1, -1);  // short line
        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h80, -1, -1);          // recovers
        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h10, -1, -1);          // thr change mid-frame
        run_frame(V, -1, 0, 1'b1, 8'h10, 8'h10, -1, -1);          // new thr next frame
        run_frame(V, 5, LINE_B - 1, 1'b1, 8'h40, 8'h40, -1, -1);  // partial trailing byte
        run_frame(V, 0, LINE_B + 4, 1'b1, 8'h40, 8'h40, -1, -1);  // long line
        run_frame(V + 1, -1, 0, 1'b1, 8'h40, 8'h40, -1, -1);      // extra line
        run_frame(V - 1, -1, 0, 1'b1, 8'h40, 8'h40, -1, -1);      // missing line
        run_frame(V, -1, 0, 1'b0, 8'h80, 8'h80, -1, -1);          // disabled
        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h80, -1, -1);          // re-enabled
        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h80, -1, 8'h80);       // luma == thr
        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h80, 4, -1);           // reset mid-frame
        run_frame(V, -1, 0, 1'b1, 8'h80, 8'h80, -1, -1);          // recovery
        for (int k = 0; k < 3; k++) begin
            logic [7:0] t;
            t = 8'($urandom);
            run_frame(V, -1, 0, 1'b1, t, 8'($urandom), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cam_threshold_writer.md
Name: cam_threshold_writer

Overview:
- Camera-domain front end that receives the OV-style parallel camera stream (VSYNC/HREF/8-bit data, YUV422) on cam_pclk.
- Extracts the luma byte of each pixel, binarizes it against a programmable threshold, and issues sequential 1-bit pixel writes (wr_en/wr_addr/wr_data) plus a per-frame frame_done pulse to the SPRAM frame buffer.
- It is the producer whose outputs drive the frame buffer's w_en, w_addr_pixel, w_data_bit and w_frame_done inputs.

Parameters:
- H_PIXELS, 320, active pixels per line.
- V_LINES, 240, active lines per frame; H_PIXELS*V_LINES must be a multiple of 16.
- BYTES_PER_PIXEL, 2, camera bytes per pixel.
- Y_BYTE_IDX, 1, byte index within a pixel (0..BYTES_PER_PIXEL-1) that carries luma.
- INVERT, 0, 1 = write (Y < threshold) instead of (Y >= threshold).

Ports:
- w_clk  in  1  camera pixel clock (cam_pclk); all logic on its rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- cam_vsync  in  1  frame sync, high during vertical blank.
- cam_href  in  1  line valid, high while active bytes are presented.
- cam_data  in  8  camera byte.
- threshold  in  8  binarization level; quasi-static.
- enable  in  1  capture enable; sampled only at frame start.
- wr_en  out  1  one-cycle pixel write strobe.
- wr_addr  out  17  pixel address 0..H_PIXELS*V_LINES-1.
- wr_data  out  1  binarized pixel.
- frame_done  out  1  one-cycle pulse: complete, well-formed frame written.
- frame_error  out  1  one-cycle pulse: captured frame malformed, discarded.
- busy  out  1  high while in ACTIVE state.

Behaviour:
- Reset is asynchronous and active-low on w_rst_n; clock is w_clk. On reset, all outputs are 0, the FSM goes to SYNC, and all counters clear.
- Input registering: cam_vsync, cam_href and cam_data are registered once (stage s1). All decisions use the s1 values.
- Output timing: wr_en/wr_addr/wr_data are registered. A luma byte sampled into s1 at edge k produces wr_en high after edge k+1.
- wr_addr and wr_data hold their last values while wr_en is low.
- FSM states:
  - SYNC: entered after reset. Waits for s1 vsync high, so a partial frame is never captured. Then goes to VBLANK.
  - VBLANK: on s1 vsync falling edge:
    - If enable = 1: latch threshold into thr_q, clear row/col/byte-phase/pixel counters and the error flag, and go to ACTIVE.
    - Otherwise stay in VBLANK. No writes are issued for that frame.
  - ACTIVE: captures lines. On s1 vsync rising edge, evaluate the frame and go to VBLANK:
    - If pixel count == H_PIXELS*V_LINES and the error flag is clear: frame_done pulses 1 cycle.
    - Otherwise: frame_error pulses 1 cycle and frame_done stays 0.
- Line handling in ACTIVE:
  - s1 href rising clears col and byte phase.
  - Each s1 href-high cycle advances byte phase modulo BPP.
  - On the cycle where byte phase == Y_BYTE_IDX and col < H_PIXELS and row < V_LINES:
    - Issue a write with wr_addr = line_base + col.
    - wr_data = (byte >= thr_q) XOR INVERT.
    - Increment the pixel count.
  - col increments when byte phase == BPP-1.
- Address arithmetic: line_base is incremental (+H_PIXELS per completed line); no multiplier. Addresses are strictly sequential within a frame with no gaps.
- Line end (s1 href falling):
  - If col != H_PIXELS, set the error flag.
  - Increment row and add H_PIXELS to line_base.
  - If row was already >= V_LINES, set the error flag. Extra lines and extra pixels are never written.
- A partial trailing byte (href falls mid-pixel) counts as a short line and sets the error flag.
- frame_done always follows the last wr_en of the frame by at least 1 cycle. frame_done and wr_en are never high in the same cycle.
- Threshold changes mid-frame have no effect until the next frame start.
- Reset asserted mid-frame: outputs clear immediately, no frame_done is emitted, and the FSM restarts in SYNC.

Test Plan:
- Nominal frame: 240 lines × 640 bytes, luma = col[7:0], threshold = 0x80, Y_BYTE_IDX = 1, with blanking between lines.
  - Expect 76800 wr_en pulses, addresses 0..76799 in order.
  - Expect wr_data = 1 exactly for cols 128..255 of each line.
  - Expect one frame_done pulse after vsync rises, and frame_error = 0.
- Short line: line 10 carries 638 bytes.
  - Expect no writes beyond col 318 on that line.
  - Expect frame_error pulse, frame_done = 0, and the next good frame yields frame_done.
- Startup mid-frame: release reset while vsync is low and href is toggling.
  - Expect no wr_en until after the next vsync high→low transition.
  - Expect the first write address to be 0.
- Threshold/INVERT: threshold changed to 0x10 mid-frame.
  - Expect the old level used until the frame ends and the new level from the next frame.
  - With INVERT = 1, a constant luma of 0x80 at threshold 0x80 writes all 0.
- enable = 0 at a vsync fall:
  - Expect zero wr_en, frame_done and frame_error for that frame.
  - Re-enable and expect a normal frame_done on the next frame.
- Reset pulse at pixel 40000:
  - Expect all outputs 0 immediately and no frame_done for that frame.
  - Expect recovery to a full good frame two vsyncs later.
